// File: rtl/lcd_shadow_rx.sv
// lcd_shadow_rx
//   Receiver end of the 8-bit HD44780-style text-LCD bus. It decodes write
//   cycles and keeps a 2x16 shadow of display RAM. It also tracks the DDRAM
//   address counter and the display-control flags.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-low reset
//   lcd_e        enable strobe; a transfer is its falling edge
//   lcd_rs       0 = command, 1 = data
//   lcd_rw       0 = write, 1 = read (reads are ignored)
//   lcd_data     bus byte
//   rd_addr      shadow index {line, column[3:0]}
//   rd_data      shadow byte at rd_addr, one-cycle latency
//   cursor_addr  DDRAM address counter
//   display_on   display-control D bit
//   cursor_on    display-control C bit
//   blink_on     display-control B bit
//   busy         high while the clear sequence sweeps the shadow
//   cmd_valid    one-cycle pulse per accepted command
//   cmd_byte     last accepted command byte
//   char_valid   one-cycle pulse per character stored in the shadow
//   err          sticky protocol error (cleared only by reset)
module lcd_shadow_rx #(
  parameter logic [7:0] CLR_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       char_valid,
  output logic       err
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t     r_state, w_state_next;
  logic [4:0] r_clr_idx;

  logic       r_e_q, r_rs_q, r_rw_q;
  logic [7:0] r_data_q;

  logic [6:0] r_cursor;
  logic       r_inc, r_ddram;
  logic       r_disp, r_curs, r_blink;
  logic       r_cmd_valid, r_char_valid, r_err;
  logic [7:0] r_cmd_byte, r_rd_data;

  // The shadow needs a full reset fill, so it is kept in registers.
  logic [7:0] r_shadow [32];

  logic       w_xfer, w_wr, w_accept, w_cmd, w_dat, w_drop, w_addr_ok;
  logic [4:0] w_wr_idx;

  // DDRAM address step. The two display lines live at 0x00-0x0F and
  // 0x40-0x4F. Stepping past the end of one line wraps to the other line.
  function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h0F)      return 7'h40;
      else if (a == 7'h4F) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h4F;
      else if (a == 7'h40) return 7'h0F;
      else                 return a - 7'd1;
    end
  endfunction

  // Falling edge of the registered enable. The byte and control bits come
  // from the copy captured while E was high.
  assign w_xfer    = r_e_q & ~lcd_e;
  assign w_wr      = w_xfer & ~r_rw_q;
  assign w_accept  = w_wr & (r_state == S_IDLE);
  assign w_drop    = w_wr & (r_state == S_CLEAR);
  assign w_cmd     = w_accept & ~r_rs_q;
  assign w_dat     = w_accept & r_rs_q;
  assign w_addr_ok = r_ddram & ((r_cursor[6:4] == 3'b000) | (r_cursor[6:4] == 3'b100));
  assign w_wr_idx  = {r_cursor[6], r_cursor[3:0]};

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd && r_data_q == 8'h01) w_state_next = S_CLEAR;
      S_CLEAR: if (r_clr_idx == 5'd31)         w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_e_q        <= 1'b0;
      r_rs_q       <= 1'b0;
      r_rw_q       <= 1'b0;
      r_data_q     <= 8'h00;
      r_cursor     <= 7'h00;
      r_inc        <= 1'b1;
      r_ddram      <= 1'b1;
      r_disp       <= 1'b0;
      r_curs       <= 1'b0;
      r_blink      <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_char_valid <= 1'b0;
      r_cmd_byte   <= 8'h00;
      r_err        <= 1'b0;
      r_rd_data    <= 8'h00;
      r_clr_idx    <= 5'd0;
      for (int i = 0; i < 32; i++) r_shadow[i] <= CLR_CHAR;
    end else begin
      r_e_q        <= lcd_e;
      r_rs_q       <= lcd_rs;
      r_rw_q       <= lcd_rw;
      r_data_q     <= lcd_data;
      r_cmd_valid  <= w_cmd;
      r_char_valid <= w_dat & w_addr_ok;
      // Non-blocking read: a same-cycle write is seen one cycle later.
      r_rd_data    <= r_shadow[rd_addr];

      if (w_drop) r_err <= 1'b1;

      // The index wraps 31 -> 0. This leaves it at 0 for the next clear.
      if (r_state == S_CLEAR) begin
        r_shadow[r_clr_idx] <= CLR_CHAR;
        r_clr_idx           <= r_clr_idx + 5'd1;
      end

      // Commands are decoded by their highest set bit.
      if (w_cmd) begin
        r_cmd_byte <= r_data_q;
        if (r_data_q[7]) begin
          r_cursor <= r_data_q[6:0];
          r_ddram  <= 1'b1;
        end else if (r_data_q[6]) begin
          r_ddram <= 1'b0;
        end else if (r_data_q[5]) begin
          if (!r_data_q[4]) r_err <= 1'b1;  // 4-bit interface is unsupported
        end else if (r_data_q[4]) begin
          if (!r_data_q[3]) r_cursor <= f_step(r_cursor, r_data_q[2]);
        end else if (r_data_q[3]) begin
          r_disp  <= r_data_q[2];
          r_curs  <= r_data_q[1];
          r_blink <= r_data_q[0];
        end else if (r_data_q[2]) begin
          r_inc <= r_data_q[1];
        end else if (r_data_q[1]) begin
          r_cursor <= 7'h00;
        end else if (r_data_q[0]) begin
          r_cursor  <= 7'h00;
          r_inc     <= 1'b1;
          r_ddram   <= 1'b1;
          r_clr_idx <= 5'd0;
        end
      end

      // The address always steps, even when the byte cannot be stored.
      if (w_dat) begin
        if (w_addr_ok) r_shadow[w_wr_idx] <= r_data_q;
        r_cursor <= f_step(r_cursor, r_inc);
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign cursor_addr = r_cursor;
  assign display_on  = r_disp;
  assign cursor_on   = r_curs;
  assign blink_on    = r_blink;
  assign busy        = (r_state == S_CLEAR);
  assign cmd_valid   = r_cmd_valid;
  assign cmd_byte    = r_cmd_byte;
  assign char_valid  = r_char_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_lcd_shadow_rx.sv
module tb_lcd_shadow_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, busy;
  logic       cmd_valid, char_valid, err;
  logic [7:0] cmd_byte;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lcd_shadow_rx #(.CLR_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .busy(busy), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .char_valid(char_valid), .err(err)
  );

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    logic       ecmd;
    logic       echar;
    logic [6:0] ecur;
    logic [2:0] eflags;
    logic       eerr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_mem [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling clock edge; returns just after the falling
  // edge that follows the cycle in which the transfer took effect.
  task automatic bus_wr(input logic rs, input logic rw, input logic [7:0] d,
                        output logic got_cmd, output logic got_char);
    lcd_e = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
    @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
    got_cmd  = cmd_valid;
    got_char = char_valid;
    $display("xfer rs=%0b rw=%0b d=%02h -> cmd_valid=%0b char_valid=%0b cursor=%02h err=%0b",
             rs, rw, d, got_cmd, got_char, cursor_addr, err);
  endtask

  task automatic read_chk(input int idx, input logic [7:0] exp);
    rd_addr = idx[4:0];
    @(negedge clk);
    chk($sformatf("shadow[%0d]", idx), {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic do_reset();
    lcd_e = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic       gc, gch;
    logic [7:0] exp_cb;
    int         busy_cnt, char_seen;

    rst = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00; rd_addr = 5'd0;
    repeat (3) @(negedge clk);

    // Reset state, sampled while reset is still asserted.
    chk("rst rd_data",    {24'h0, rd_data},     32'h0);
    chk("rst cursor",     {25'h0, cursor_addr}, 32'h0);
    chk("rst flags",      {29'h0, display_on, cursor_on, blink_on}, 32'h0);
    chk("rst busy",       {31'h0, busy},        32'h0);
    chk("rst err",        {31'h0, err},         32'h0);
    chk("rst cmd_byte",   {24'h0, cmd_byte},    32'h0);
    chk("rst pulses",     {30'h0, cmd_valid, char_valid}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) read_chk(i, 8'h20);

    //            rs    rw    d      cmd   char  cursor  flags    err
    vecs.push_back('{1'b0, 1'b0, 8'h38, 1'b1, 1'b0, 7'h00, 3'b000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h0C, 1'b1, 1'b0, 7'h00, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 7'h00, 3'b100, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 7'h01, 3'b100, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h42, 1'b0, 1'b1, 7'h02, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h8F, 1'b1, 1'b0, 7'h0F, 3'b100, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h58, 1'b0, 1'b1, 7'h40, 3'b100, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h59, 1'b0, 1'b1, 7'h41, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 7'h41, 3'b100, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 7'h41, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 7'h41, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 7'h00, 3'b100, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 7'h4F, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h14, 1'b1, 1'b0, 7'h00, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 7'h4F, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h18, 1'b1, 1'b0, 7'h4F, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'hC5, 1'b1, 1'b0, 7'h45, 3'b100, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h43, 1'b0, 1'b1, 7'h44, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h06, 1'b1, 1'b0, 7'h44, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 7'h00, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h97, 1'b1, 1'b0, 7'h17, 3'b100, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 7'h18, 3'b100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h0B, 1'b1, 1'b0, 7'h18, 3'b011, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h28, 1'b1, 1'b0, 7'h18, 3'b011, 1'b1});

    exp_cb = 8'h00;
    foreach (vecs[k]) begin
      bus_wr(vecs[k].rs, vecs[k].rw, vecs[k].d, gc, gch);
      if (vecs[k].ecmd) exp_cb = vecs[k].d;
      chk($sformatf("v%0d cmd_valid", k),  {31'h0, gc},          {31'h0, vecs[k].ecmd});
      chk($sformatf("v%0d char_valid", k), {31'h0, gch},         {31'h0, vecs[k].echar});
      chk($sformatf("v%0d cursor", k),     {25'h0, cursor_addr}, {25'h0, vecs[k].ecur});
      chk($sformatf("v%0d flags", k),      {29'h0, display_on, cursor_on, blink_on}, {29'h0, vecs[k].eflags});
      chk($sformatf("v%0d err", k),        {31'h0, err},         {31'h0, vecs[k].eerr});
      chk($sformatf("v%0d cmd_byte", k),   {24'h0, cmd_byte},    {24'h0, exp_cb});
    end

    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    exp_mem[0] = 8'h5A; exp_mem[1] = 8'h42; exp_mem[15] = 8'h58;
    exp_mem[16] = 8'h59; exp_mem[21] = 8'h43;
    for (int i = 0; i < 32; i++) read_chk(i, exp_mem[i]);

    // Clear sequence: busy for 32 cycles, and a write arriving mid-clear is dropped.
    do_reset();
    bus_wr(1'b1, 1'b0, 8'h41, gc, gch);
    chk("pre-clear char_valid", {31'h0, gch}, 32'h1);
    bus_wr(1'b0, 1'b0, 8'h01, gc, gch);
    chk("clear cmd_valid", {31'h0, gc}, 32'h1);
    busy_cnt = 0; char_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy)       busy_cnt++;
      if (char_valid) char_seen++;
      if (i == 3) begin lcd_e = 1'b1; lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h77; end
      if (i == 4) lcd_e = 1'b0;
      @(negedge clk);
    end
    $display("clear sweep: busy cycles=%0d char pulses=%0d err=%0b", busy_cnt, char_seen, err);
    chk("clear busy cycles", busy_cnt, 32);
    chk("clear char pulses", char_seen, 0);
    chk("clear drop err",    {31'h0, err},         32'h1);
    chk("clear cursor",      {25'h0, cursor_addr}, 32'h0);
    chk("clear busy done",   {31'h0, busy},        32'h0);
    for (int i = 0; i < 32; i++) read_chk(i, 8'h20);

    // CGRAM mode: data is dropped but the address still steps.
    bus_wr(1'b0, 1'b0, 8'h40, gc, gch);
    chk("cgram cmd_valid", {31'h0, gc}, 32'h1);
    bus_wr(1'b1, 1'b0, 8'h1F, gc, gch);
    chk("cgram char_valid", {31'h0, gch},         32'h0);
    chk("cgram cursor",     {25'h0, cursor_addr}, 32'h1);
    chk("cgram err sticky", {31'h0, err},         32'h1);
    read_chk(0, 8'h20);
    read_chk(1, 8'h20);

    // Reset in the middle of a clear.
    bus_wr(1'b0, 1'b0, 8'h0F, gc, gch);
    bus_wr(1'b0, 1'b0, 8'hCF, gc, gch);
    bus_wr(1'b1, 1'b0, 8'h41, gc, gch);
    chk("line wrap cursor", {25'h0, cursor_addr}, 32'h0);
    read_chk(31, 8'h41);
    bus_wr(1'b0, 1'b0, 8'h01, gc, gch);
    repeat (10) @(negedge clk);
    chk("mid-clear busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy",     {31'h0, busy},        32'h0);
    chk("abort cursor",   {25'h0, cursor_addr}, 32'h0);
    chk("abort flags",    {29'h0, display_on, cursor_on, blink_on}, 32'h0);
    chk("abort err",      {31'h0, err},         32'h0);
    chk("abort cmd_byte", {24'h0, cmd_byte},    32'h0);
    chk("abort rd_data",  {24'h0, rd_data},     32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("after abort busy", {31'h0, busy}, 32'h0);
    read_chk(31, 8'h20);
    read_chk(0, 8'h20);
    bus_wr(1'b1, 1'b0, 8'h44, gc, gch);
    chk("post-reset char_valid", {31'h0, gch},         32'h1);
    chk("post-reset cursor",     {25'h0, cursor_addr}, 32'h1);
    read_chk(0, 8'h44);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_shadow_rx.md
Name: lcd_shadow_rx

Overview:
- Responder/receiver end of the 8-bit text-LCD bus (lcd_e, lcd_rs, lcd_rw, lcd_data) that the puzzle and calculator modes drive.
- Decodes HD44780-style write cycles and keeps a 2x16 shadow copy of display RAM, cursor address and display flags.
- Exposes the shadow through a registered read port and event strobes.
- Serves as an on-chip bus monitor for mode-switch and self-check logic, and as the LCD model in benches.

Parameters:
- CLR_CHAR, 8'h20: fill value for reset and the clear-display command.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; **synchronous and active-low**
- lcd_e  input  1  LCD enable strobe, same clock domain
- lcd_rs  input  1  0 = command, 1 = data
- lcd_rw  input  1  0 = write, 1 = read
- lcd_data  input  8  bus byte
- rd_addr  input  5  shadow index; bit4 = line, bits3:0 = column
- rd_data  output  8  shadow byte at rd_addr, one-cycle latency
- cursor_addr  output  7  current DDRAM address counter
- display_on  output  1  display-control D bit
- cursor_on  output  1  display-control C bit
- blink_on  output  1  display-control B bit
- busy  output  1  high while a clear sequence runs
- cmd_valid  output  1  one-cycle pulse per accepted command
- cmd_byte  output  8  last accepted command byte
- char_valid  output  1  one-cycle pulse per stored character
- err  output  1  sticky protocol error

Behaviour:
- Bus capture:
  - lcd_e/rs/rw/data are registered every cycle.
  - A transfer is a falling edge of the registered E (e_q=1, lcd_e=0); rs/rw/data are taken from the registered copy.
  - Effects and pulses appear on the cycle after edge detection.
  - rw=1 transfers are ignored with no effect.
- Reset (rst=0 at a clock edge):
  - All 32 shadow bytes = CLR_CHAR; cursor_addr=0; increment mode=1; DDRAM mode selected.
  - display_on, cursor_on, blink_on, busy, cmd_valid, char_valid, err = 0; cmd_byte = 0; rd_data = 0.
  - Reset mid-clear aborts the clear and returns the FSM to IDLE.
- FSM:
  - IDLE: decodes transfers.
  - CLEAR: one shadow entry per cycle, index 0..31, for 32 cycles; busy=1; then back to IDLE.
  - Any transfer arriving in CLEAR is dropped and sets err.
- Commands (rs=0, rw=0), decoded by highest set bit; cmd_valid pulses and cmd_byte updates for every one:
  - 0x01 clear: enter CLEAR; cursor_addr=0; increment=1; DDRAM mode.
  - 0x02–0x03 home: cursor_addr=0.
  - 0x04–0x07 entry mode: increment = bit1; shift bit ignored.
  - 0x08–0x0F display control: display_on=bit2, cursor_on=bit1, blink_on=bit0.
  - 0x10–0x1F shift: if bit3=0, cursor moves one step right (bit2=1) or left (bit2=0) using the address-step rule; if bit3=1, ignored.
  - 0x20–0x3F function set: if DL (bit4)=0, set err.
  - 0x40–0x7F CGRAM address: switch to CGRAM mode.
  - 0x80–0xFF: cursor_addr = data[6:0]; switch to DDRAM mode.
- Data write (rs=1, rw=0):
  - In DDRAM mode with cursor_addr in 0x00–0x0F or 0x40–0x4F: store at index {cursor_addr[6], cursor_addr[3:0]} and pulse char_valid.
  - Otherwise (CGRAM mode or invalid address): byte dropped, no char_valid.
  - The address steps after every data write, including dropped ones.
- Address step rule:
  - Increment: +1 mod 128, except 0x0F→0x40 and 0x4F→0x00.
  - Decrement: −1 mod 128, except 0x00→0x4F and 0x40→0x0F.
- Read port:
  - rd_data registered every cycle from shadow[rd_addr].
  - A read of an index written in the same cycle returns the old value.
- err is cleared only by reset.

Test Plan:
- Reset, then read all 32 indices → each 0x20; cursor_addr=0, display_on=0, err=0.
- Send 0x38, 0x0C, 0x80, then data "AB" → display_on=1, cursor_on=0, shadow[0]=0x41, shadow[1]=0x42, cursor_addr=0x02, two char_valid pulses.
- Send 0x8F then data 0x58, 0x59 → shadow[15]=0x58, shadow[16]=0x59, cursor_addr=0x41.
- Send 0x04, 0x80, data 0x5A → shadow[0]=0x5A, cursor_addr=0x4F; then 0x14 → cursor_addr=0x00.
- Send 0x01, then a data write 5 cycles later → busy high for 32 cycles, all shadow bytes 0x20, the write dropped, err=1.
- Send 0x40 then data 0x1F → no char_valid, shadow unchanged, cursor_addr stepped by 1; then assert rst mid-clear → busy=0 and state matches reset values.
